// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bundle layouts and NOP values for the
// inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

  // occupancy encoding doubles as the stage state
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } slot_state_e;

  // control widths per boundary
  localparam int IFID_CTRL_W  = 8;
  localparam int IDEX_CTRL_W  = 40;
  localparam int EXMEM_CTRL_W = 24;
  localparam int MEMWB_CTRL_W = 8;

  // IF/ID control fields
  localparam int IFID_PANIC = 0;
  localparam int IFID_IRET  = 1;

  // ID/EX control fields (offset of lsb)
  localparam int IDEX_ALU_OP        = 0;
  localparam int IDEX_ALU_OP_W      = 4;
  localparam int IDEX_USE_IMM       = 4;
  localparam int IDEX_WRITE_REG     = 5;
  localparam int IDEX_LOAD          = 6;
  localparam int IDEX_STORE         = 7;
  localparam int IDEX_MEM_SIZE      = 8;
  localparam int IDEX_MEM_SIZE_W    = 2;
  localparam int IDEX_LOAD_UNSIGNED = 10;
  localparam int IDEX_BRANCH        = 11;
  localparam int IDEX_BRANCH_OP     = 12;
  localparam int IDEX_BRANCH_OP_W   = 3;
  localparam int IDEX_JUMP          = 15;
  localparam int IDEX_PANIC         = 16;
  localparam int IDEX_MOV_RM        = 17;
  localparam int IDEX_TLBWRITE      = 18;
  localparam int IDEX_IRET          = 19;
  localparam int IDEX_RD            = 20;
  localparam int IDEX_RS1           = 25;
  localparam int IDEX_RS2           = 30;
  localparam int IDEX_REG_W         = 5;

  // EX/MEM control fields
  localparam int EXMEM_WRITE_REG     = 0;
  localparam int EXMEM_LOAD          = 1;
  localparam int EXMEM_STORE         = 2;
  localparam int EXMEM_MEM_SIZE      = 3;
  localparam int EXMEM_LOAD_UNSIGNED = 5;
  localparam int EXMEM_PANIC         = 6;
  localparam int EXMEM_MOV_RM        = 7;
  localparam int EXMEM_TLBWRITE      = 8;
  localparam int EXMEM_IRET          = 9;
  localparam int EXMEM_RD            = 10;

  // MEM/WB control fields
  localparam int MEMWB_WRITE_REG = 0;
  localparam int MEMWB_RD        = 1;

  // NOPs: mem_size defaults to word so an idle slot never
  // presents a sub-word access encoding
  localparam logic [IFID_CTRL_W-1:0] IFID_CTRL_NOP = '0;
  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_NOP =
    IDEX_CTRL_W'(2'b10) << IDEX_MEM_SIZE;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP =
    EXMEM_CTRL_W'(2'b10) << EXMEM_MEM_SIZE;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one data+ctrl register. load takes d_*, clear resets
// ctrl to CTRL_NOP while keeping data; otherwise holds.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 40,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_data <= '0;
      q_ctrl <= CTRL_NOP;
    end else if (clear) begin
      q_ctrl <= CTRL_NOP;
    end else if (load) begin
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked stage register with bubble, flush and
// optional skid slot.
// Ports: in_* upstream beat/handshake, in_bubble/in_flush controls,
// out_* downstream beat/handshake, occupancy = held beats (0..2).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 40,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int unsigned SKID = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_bubble,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  slot_state_e state_q, state_d;

  logic acc, drain, adv, bub;
  logic main_ld, main_clr, main_from_skid;
  logic skid_ld, skid_clr;

  logic [DATA_W-1:0] main_d_data, skid_q_data;
  logic [CTRL_W-1:0] main_d_ctrl, skid_q_ctrl;

  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign adv   = !out_valid | out_ready;
  assign drain = out_valid & out_ready;
  assign acc   = in_valid & in_ready;
  assign bub   = in_bubble & adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  // With SKID=0 state TWO is unreachable: in_ready already
  // requires the main slot to advance, so ONE+accept is a reload.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (in_flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (bub) begin
      // NOP enters main ahead of anything in skid
      main_clr = 1'b1;
      if (state_q == ST_TWO) begin
        state_d = ST_TWO;
      end else if (acc) begin
        skid_ld = 1'b1;
        state_d = ST_TWO;
      end else begin
        state_d = ST_ONE;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && drain) begin
            main_ld = 1'b1;
          end else if (acc) begin
            skid_ld = 1'b1;
            state_d = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_q_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_q_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_ld),
    .clear   (main_clr),
    .d_data  (main_d_data),
    .d_ctrl  (main_d_ctrl),
    .q_data  (out_data),
    .q_ctrl  (out_ctrl)
  );

  if (SKID != 0) begin : g_skid
    logic rdy_q;

    // ready is a flop: next state not TWO
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdy_q <= 1'b1;
      else          rdy_q <= (state_d != ST_TWO);
    end

    assign in_ready = rdy_q;

    pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_NOP (CTRL_NOP)
    ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (skid_ld),
      .clear   (skid_clr),
      .d_data  (in_data),
      .d_ctrl  (in_ctrl),
      .q_data  (skid_q_data),
      .q_ctrl  (skid_q_ctrl)
    );
  end else begin : g_noskid
    logic unused_skid;

    assign in_ready    = adv & !in_bubble;
    assign skid_q_data = '0;
    assign skid_q_ctrl = CTRL_NOP;
    assign unused_skid = skid_ld | skid_clr;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for SKID=1 (a_*) and SKID=0
// (b_*) instances with a per-instance in-order scoreboard.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 160;
  localparam int CW = 40;
  localparam logic [CW-1:0] NOP = IDEX_CTRL_NOP;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_in_bubble, a_in_flush;
  logic          a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]    a_occ;

  logic          b_in_valid, b_in_ready, b_in_bubble, b_in_flush;
  logic          b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [1:0]    b_occ;

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1)
  ) u_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .in_bubble(a_in_bubble), .in_flush(a_in_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .in_bubble(b_in_bubble), .in_flush(b_in_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ)
  );

  int checks = 0;
  int errors = 0;
  bit sb_en = 1'b1;

  logic [DW+CW-1:0] qa[$];
  logic [DW+CW-1:0] qb[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: push accepted stimulus, pop on each drain
  always @(negedge clk) begin
    logic [DW+CW-1:0] e;
    if (!reset_n) begin
      qa.delete();
    end else if (sb_en) begin
      if (a_out_valid && a_out_ready) begin
        chk("a_sb_nonempty", DW'(qa.size() != 0), DW'(1));
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_sb_data", a_out_data, e[CW+:DW]);
          chk("a_sb_ctrl", DW'(a_out_ctrl), DW'(e[CW-1:0]));
        end
      end
      if (a_in_flush) qa.delete();
      else if (a_in_valid && a_in_ready)
        qa.push_back({a_in_data, a_in_ctrl});
    end
  end

  always @(negedge clk) begin
    logic [DW+CW-1:0] e;
    if (!reset_n) begin
      qb.delete();
    end else if (sb_en) begin
      if (b_out_valid && b_out_ready) begin
        chk("b_sb_nonempty", DW'(qb.size() != 0), DW'(1));
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_sb_data", b_out_data, e[CW+:DW]);
          chk("b_sb_ctrl", DW'(b_out_ctrl), DW'(e[CW-1:0]));
        end
      end
      if (b_in_flush) qb.delete();
      else if (b_in_valid && b_in_ready)
        qb.push_back({b_in_data, b_in_ctrl});
    end
  end

  initial begin
    reset_n = 1'b1;
    {a_in_valid, a_in_bubble, a_in_flush, a_out_ready} = '0;
    {b_in_valid, b_in_bubble, b_in_flush, b_out_ready} = '0;
    a_in_data = '0; a_in_ctrl = '0;
    b_in_data = '0; b_in_ctrl = '0;
    #2 reset_n = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_a_valid", DW'(a_out_valid), DW'(0));
    chk("rst_a_occ", DW'(a_occ), DW'(0));
    chk("rst_a_ctrl", DW'(a_out_ctrl), DW'(NOP));
    chk("rst_a_data", a_out_data, DW'(0));
    chk("rst_b_valid", DW'(b_out_valid), DW'(0));
    reset_n = 1'b1;
    #1;
    chk("rst_a_ready", DW'(a_in_ready), DW'(1));
    chk("rst_b_ready", DW'(b_in_ready), DW'(1));

    // SKID=1 back-pressure and ordering
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 40'h01; a_in_data = 160'hD1;
    tick();
    chk("bp_occ1", DW'(a_occ), DW'(1));
    chk("bp_valid1", DW'(a_out_valid), DW'(1));
    a_in_ctrl = 40'h02; a_in_data = 160'hD2;
    tick();
    chk("bp_occ2", DW'(a_occ), DW'(2));
    chk("bp_ready0", DW'(a_in_ready), DW'(0));
    a_in_ctrl = 40'h03; a_in_data = 160'hD3;
    tick();
    chk("bp_hold_occ", DW'(a_occ), DW'(2));
    chk("bp_hold_ctrl", DW'(a_out_ctrl), DW'(40'h01));
    chk("bp_hold_data", a_out_data, DW'(160'hD1));
    a_out_ready = 1'b1;
    tick();
    chk("bp_skid2main", DW'(a_out_ctrl), DW'(40'h02));
    chk("bp_ready1", DW'(a_in_ready), DW'(1));
    tick();
    chk("bp_third", DW'(a_out_ctrl), DW'(40'h03));
    chk("bp_third_occ", DW'(a_occ), DW'(1));
    a_in_valid = 1'b0;
    tick();
    chk("bp_empty", DW'(a_occ), DW'(0));
    chk("bp_sb_done", DW'(qa.size()), DW'(0));

    // flush at occupancy 2 with an incoming beat
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 40'h10; a_in_data = 160'hA10;
    tick();
    a_in_ctrl = 40'h11; a_in_data = 160'hA11;
    tick();
    chk("fl_occ2", DW'(a_occ), DW'(2));
    a_in_flush = 1'b1; a_in_ctrl = 40'h12; a_in_data = 160'hA12;
    tick();
    chk("fl_valid", DW'(a_out_valid), DW'(0));
    chk("fl_occ", DW'(a_occ), DW'(0));
    chk("fl_ready", DW'(a_in_ready), DW'(1));
    chk("fl_ctrl", DW'(a_out_ctrl), DW'(NOP));
    chk("fl_data", a_out_data, DW'(160'hA10));
    // flush in a cycle where the beat is accepted
    a_in_ctrl = 40'h13; a_in_data = 160'hA13;
    tick();
    chk("fl_acc_valid", DW'(a_out_valid), DW'(0));
    // flush beats bubble
    a_out_ready = 1'b1; a_in_bubble = 1'b1;
    a_in_ctrl = 40'h14; a_in_data = 160'hA14;
    tick();
    chk("flbub_valid", DW'(a_out_valid), DW'(0));
    a_in_flush = 1'b0; a_in_bubble = 1'b0; a_in_valid = 1'b0;
    tick(); tick();
    chk("fl_never", DW'(a_out_valid), DW'(0));

    // SKID=1 bubble
    sb_en = 1'b0;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 40'h2A; a_in_data = 160'h1234;
    tick();
    a_in_ctrl = 40'h2B; a_in_data = 160'h5678;
    a_out_ready = 1'b1; a_in_bubble = 1'b1;
    tick();
    chk("bub_a_valid", DW'(a_out_valid), DW'(1));
    chk("bub_a_ctrl", DW'(a_out_ctrl), DW'(NOP));
    chk("bub_a_data", a_out_data, DW'(160'h1234));
    chk("bub_a_occ", DW'(a_occ), DW'(2));
    a_in_bubble = 1'b0; a_in_valid = 1'b0;
    tick();
    chk("bub_a_next_ctrl", DW'(a_out_ctrl), DW'(40'h2B));
    chk("bub_a_next_data", a_out_data, DW'(160'h5678));
    tick();
    chk("bub_a_drained", DW'(a_out_valid), DW'(0));
    sb_en = 1'b1;

    // SKID=0 streaming
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_ctrl = CW'(40'h40 + i);
      b_in_data = DW'(160'h100 + i);
      #1;
      chk("s0_ready", DW'(b_in_ready), DW'(1));
      tick();
      chk("s0_valid", DW'(b_out_valid), DW'(1));
      chk("s0_ctrl", DW'(b_out_ctrl), DW'(40'h40 + i));
    end
    b_in_valid = 1'b0;
    tick();
    chk("s0_empty", DW'(b_out_valid), DW'(0));
    chk("s0_sb_done", DW'(qb.size()), DW'(0));

    // SKID=0 bubble
    sb_en = 1'b0;
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = 40'h2A; b_in_data = 160'h1234;
    tick();
    b_in_ctrl = 40'h2B; b_in_data = 160'h5678;
    b_out_ready = 1'b1; b_in_bubble = 1'b1;
    #1;
    chk("bub_b_ready0", DW'(b_in_ready), DW'(0));
    tick();
    chk("bub_b_valid", DW'(b_out_valid), DW'(1));
    chk("bub_b_ctrl", DW'(b_out_ctrl), DW'(NOP));
    chk("bub_b_data", b_out_data, DW'(160'h1234));
    b_in_bubble = 1'b0;
    #1;
    chk("bub_b_ready1", DW'(b_in_ready), DW'(1));
    tick();
    chk("bub_b_next_ctrl", DW'(b_out_ctrl), DW'(40'h2B));
    chk("bub_b_next_data", b_out_data, DW'(160'h5678));
    b_in_valid = 1'b0;
    tick();
    chk("bub_b_drained", DW'(b_out_valid), DW'(0));
    sb_en = 1'b1;

    // asynchronous reset at occupancy 2
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 40'h20; a_in_data = 160'hB20;
    tick();
    a_in_ctrl = 40'h21; a_in_data = 160'hB21;
    tick();
    a_in_valid = 1'b0;
    chk("ar_occ2", DW'(a_occ), DW'(2));
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", DW'(a_out_valid), DW'(0));
    chk("ar_occ", DW'(a_occ), DW'(0));
    chk("ar_ctrl", DW'(a_out_ctrl), DW'(NOP));
    tick();
    reset_n = 1'b1;
    #1;
    chk("ar_ready", DW'(a_in_ready), DW'(1));
    a_out_ready = 1'b1;
    tick(); tick();
    chk("ar_lost", DW'(a_out_valid), DW'(0));
    chk("end_qa", DW'(qa.size()), DW'(0));
    chk("end_qb", DW'(qb.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
